// File: rtl/vga_timing_gen.sv
// Raster timing for the VGA path: position counters, visible flag,
// line/frame strobes and polarity-configurable, delay-aligned syncs.
//
// Ports:
//   vga_pix_clk     pixel clock (only clock)
//   rst             asynchronous active-low reset
//   sx, sy          registered pixel position
//   display_enabled high inside the visible area
//   line_stb        one-cycle pulse at sx == 0
//   frame_stb       one-cycle pulse at sx == 0, sy == V_VISIBLE_AREA
//   hsync, vsync    sync outputs, SYNC_DELAY cycles behind sx/sy
module vga_timing_gen #(
    parameter int   H_VISIBLE_AREA = 640,
    parameter int   H_FRONT_PORCH  = 16,
    parameter int   H_SYNC_PULSE   = 96,
    parameter int   H_BACK_PORCH   = 48,
    parameter int   V_VISIBLE_AREA = 480,
    parameter int   V_FRONT_PORCH  = 10,
    parameter int   V_SYNC_PULSE   = 2,
    parameter int   V_BACK_PORCH   = 33,
    parameter logic H_SYNC_POL     = 1'b0,
    parameter logic V_SYNC_POL     = 1'b0,
    parameter int   SYNC_DELAY     = 2,
    localparam int  H_WHOLE_LINE   = H_VISIBLE_AREA + H_FRONT_PORCH
                                   + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int  V_WHOLE_LINE   = V_VISIBLE_AREA + V_FRONT_PORCH
                                   + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int  H_ADDR_WIDTH   = $clog2(H_WHOLE_LINE),
    localparam int  V_ADDR_WIDTH   = $clog2(V_WHOLE_LINE)
) (
    input  logic                    vga_pix_clk,
    input  logic                    rst,
    output logic [H_ADDR_WIDTH-1:0] sx,
    output logic [V_ADDR_WIDTH-1:0] sy,
    output logic                    display_enabled,
    output logic                    line_stb,
    output logic                    frame_stb,
    output logic                    hsync,
    output logic                    vsync
);

    localparam int HW = H_ADDR_WIDTH;
    localparam int VW = V_ADDR_WIDTH;

    localparam logic [HW-1:0] H_LAST = HW'(H_WHOLE_LINE - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE_AREA);
    localparam logic [HW-1:0] H_SS   = HW'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SE   = HW'(H_VISIBLE_AREA + H_FRONT_PORCH
                                           + H_SYNC_PULSE);
    localparam logic [VW-1:0] V_LAST = VW'(V_WHOLE_LINE - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE_AREA);
    localparam logic [VW-1:0] V_SS   = VW'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SE   = VW'(V_VISIBLE_AREA + V_FRONT_PORCH
                                           + V_SYNC_PULSE);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          hsync_r;
    logic          vsync_r;
    logic          h_wrap;
    logic          h_act;
    logic          v_act;

    assign h_wrap = (h_cnt == H_LAST);
    assign h_act  = (h_cnt >= H_SS) && (h_cnt < H_SE);
    assign v_act  = (v_cnt >= V_SS) && (v_cnt < V_SE);

    always_ff @(posedge vga_pix_clk or negedge rst) begin
        if (!rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap)
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end
    end

    // Output stage: everything decoded from the same counter snapshot
    // so flags and strobes always agree with the sx/sy beside them.
    always_ff @(posedge vga_pix_clk or negedge rst) begin
        if (!rst) begin
            sx              <= '0;
            sy              <= '0;
            display_enabled <= 1'b0;
            line_stb        <= 1'b0;
            frame_stb       <= 1'b0;
            hsync_r         <= ~H_SYNC_POL;
            vsync_r         <= ~V_SYNC_POL;
        end else begin
            sx              <= h_cnt;
            sy              <= v_cnt;
            display_enabled <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
            line_stb        <= (h_cnt == '0);
            frame_stb       <= (h_cnt == '0) && (v_cnt == V_VIS);
            hsync_r         <= h_act ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_r         <= v_act ? V_SYNC_POL : ~V_SYNC_POL;
        end
    end

    // Delay line keeps syncs aligned with downstream RGB; reset flushes
    // it with the inactive level so no stale pulse emerges afterwards.
    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign hsync = hsync_r;
            assign vsync = vsync_r;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] h_pipe;
            logic [SYNC_DELAY-1:0] v_pipe;

            always_ff @(posedge vga_pix_clk or negedge rst) begin
                if (!rst) begin
                    h_pipe <= {SYNC_DELAY{~H_SYNC_POL}};
                    v_pipe <= {SYNC_DELAY{~V_SYNC_POL}};
                end else begin
                    h_pipe[0] <= hsync_r;
                    v_pipe[0] <= vsync_r;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        h_pipe[i] <= h_pipe[i-1];
                        v_pipe[i] <= v_pipe[i-1];
                    end
                end
            end

            assign hsync = h_pipe[SYNC_DELAY-1];
            assign vsync = v_pipe[SYNC_DELAY-1];
        end
    endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: three parameterisations checked every
// cycle against an arithmetic raster model, with random mid-frame resets.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int d;
        bit hp, vp;
    } cfg_t;

    typedef struct {
        int sx, sy;
        bit de, ls, fs, hs, vs;
    } out_t;

    localparam cfg_t C_DEF = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
    localparam cfg_t C_SML = '{8, 1, 2, 1, 4, 1, 1, 1, 0, 1'b1, 1'b1};
    localparam cfg_t C_MID = '{20, 3, 5, 4, 6, 2, 3, 2, 3, 1'b0, 1'b0};

    logic clk;
    logic rst;

    logic [9:0] d_sx, d_sy;
    logic       d_de, d_ls, d_fs, d_hs, d_vs;
    logic [3:0] s_sx;
    logic [2:0] s_sy;
    logic       s_de, s_ls, s_fs, s_hs, s_vs;
    logic [4:0] m_sx;
    logic [3:0] m_sy;
    logic       m_de, m_ls, m_fs, m_hs, m_vs;

    int n_vec;
    int n_err;
    int n;
    int last_fs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .vga_pix_clk(clk), .rst(rst),
        .sx(d_sx), .sy(d_sy), .display_enabled(d_de),
        .line_stb(d_ls), .frame_stb(d_fs),
        .hsync(d_hs), .vsync(d_vs)
    );

    vga_timing_gen #(
        .H_VISIBLE_AREA(8), .H_FRONT_PORCH(1),
        .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
        .V_VISIBLE_AREA(4), .V_FRONT_PORCH(1),
        .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1),
        .SYNC_DELAY(0)
    ) u_sml (
        .vga_pix_clk(clk), .rst(rst),
        .sx(s_sx), .sy(s_sy), .display_enabled(s_de),
        .line_stb(s_ls), .frame_stb(s_fs),
        .hsync(s_hs), .vsync(s_vs)
    );

    vga_timing_gen #(
        .H_VISIBLE_AREA(20), .H_FRONT_PORCH(3),
        .H_SYNC_PULSE(5), .H_BACK_PORCH(4),
        .V_VISIBLE_AREA(6), .V_FRONT_PORCH(2),
        .V_SYNC_PULSE(3), .V_BACK_PORCH(2),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0),
        .SYNC_DELAY(3)
    ) u_mid (
        .vga_pix_clk(clk), .rst(rst),
        .sx(m_sx), .sy(m_sy), .display_enabled(m_de),
        .line_stb(m_ls), .frame_stb(m_fs),
        .hsync(m_hs), .vsync(m_vs)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s n=%0d got %0d expected %0d",
                         tag, n, got, exp);
        end
    endtask

    // Pixel k after release (k = 0,1,..) sits at raster position
    // k mod frame; syncs show the position SYNC_DELAY pixels earlier.
    function automatic out_t ref_out(input cfg_t c, input int e);
        out_t o;
        int hw, vw, p, q, qx, qy;
        hw = c.hv + c.hf + c.hs + c.hb;
        vw = c.vv + c.vf + c.vs + c.vb;
        o = '{0, 0, 1'b0, 1'b0, 1'b0, ~c.hp, ~c.vp};
        if (e == 0) return o;
        p = (e - 1) % (hw * vw);
        o.sx = p % hw;
        o.sy = p / hw;
        o.de = (o.sx < c.hv) && (o.sy < c.vv);
        o.ls = (o.sx == 0);
        o.fs = (o.sx == 0) && (o.sy == c.vv);
        q = e - 1 - c.d;
        if (q >= 0) begin
            q  = q % (hw * vw);
            qx = q % hw;
            qy = q / hw;
            if (qx >= c.hv + c.hf && qx < c.hv + c.hf + c.hs) o.hs = c.hp;
            if (qy >= c.vv + c.vf && qy < c.vv + c.vf + c.vs) o.vs = c.vp;
        end
        return o;
    endfunction

    task automatic chk_dut(input string nm, input cfg_t c, input out_t g);
        out_t x;
        x = ref_out(c, n);
        chk({nm, "_sx"}, g.sx, x.sx);
        chk({nm, "_sy"}, g.sy, x.sy);
        chk({nm, "_de"}, int'(g.de), int'(x.de));
        chk({nm, "_line_stb"}, int'(g.ls), int'(x.ls));
        chk({nm, "_frame_stb"}, int'(g.fs), int'(x.fs));
        chk({nm, "_hsync"}, int'(g.hs), int'(x.hs));
        chk({nm, "_vsync"}, int'(g.vs), int'(x.vs));
    endtask

    task automatic chk_all();
        chk_dut("def", C_DEF,
                '{int'(d_sx), int'(d_sy), d_de, d_ls, d_fs, d_hs, d_vs});
        chk_dut("sml", C_SML,
                '{int'(s_sx), int'(s_sy), s_de, s_ls, s_fs, s_hs, s_vs});
        chk_dut("mid", C_MID,
                '{int'(m_sx), int'(m_sy), m_de, m_ls, m_fs, m_hs, m_vs});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            n++;
            chk_all();
            if (s_fs) begin
                if (last_fs >= 0) chk("sml_frame_period", n - last_fs, 84);
                last_fs = n;
            end
        end
    endtask

    // Reset asserted between edges must act without waiting for a clock.
    task automatic mid_reset();
        #2 rst = 1'b0;
        #1;
        n = 0;
        last_fs = -1;
        chk_all();
        @(negedge clk);
        chk_all();
        rst = 1'b1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        n       = 0;
        last_fs = -1;
        rst     = 1'b0;
        repeat (3) @(negedge clk);
        chk_all();
        rst = 1'b1;
        run(1700);
        mid_reset();
        run(701);
        mid_reset();
        run(900);
        for (int k = 0; k < 6; k++) begin
            mid_reset();
            run($urandom_range(20, 1700));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
